// File: rtl/pwm_pkg.sv
// Shared types and helpers for the fixed-frequency PWM block.
// Holds the phase encoding and the counter-width helper used by pwm.
package pwm_pkg;

   typedef enum logic {
      S_OFF = 1'b0,
      S_ON  = 1'b1
   } pwm_state_t;

   // Counter width for a modulus of n; a modulus of 1 still needs one bit.
   function automatic int pwm_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pwm.sv
// Fixed-frequency, fixed-duty PWM: dout is high for period_On of every period cycles.
// Define PWM_SIM_INIT_EN to give the registers power-up values equal to their reset values.
module pwm
   import pwm_pkg::*;
#(
   parameter int period    = 100,
   parameter int period_On = 50
) (
   input  logic clk,
   input  logic rst,
   output logic dout
);

   localparam int cw = pwm_width(period);

   // A high-time longer than the period saturates to a permanently-high output.
   localparam int              ton_eff_i  = (period_On > period) ? period : period_On;
   localparam logic [cw:0]     ton_eff    = (cw + 1)'(ton_eff_i);
   localparam logic [cw-1:0]   count_last = cw'(period - 1);

   if (period < 1) begin : g_period_check
      $error("pwm: period must be at least 1");
   end

`ifdef PWM_SIM_INIT_EN
   logic [cw-1:0] count  = '0;
   logic [cw:0]   ton    = ton_eff;
   pwm_state_t    state  = S_OFF;
   logic          dout_q = 1'b0;
`else
   logic [cw-1:0] count;
   logic [cw:0]   ton;
   pwm_state_t    state;
   logic          dout_q;
`endif

   logic dout_next;

   assign dout_next = ({1'b0, count} < ton);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         ton    <= ton_eff;
         state  <= S_OFF;
         dout_q <= 1'b0;
      end else begin
         dout_q <= dout_next;
         state  <= dout_next ? S_ON : S_OFF;
         count  <= (count == count_last) ? '0 : count + 1'b1;
      end
   end

   // The port is driven straight from the flop, so no glitches reach the load.
   assign dout = dout_q;

endmodule

// File: tb/tb_pwm.sv
// Self-checking bench for pwm: several parameterisations share one clock and reset,
// a spec-derived reference model feeds a scoreboard, and a segment table drives reset.
module tb_pwm;
   import pwm_pkg::*;

`ifdef PWM_SIM_INIT_EN
   localparam int NI = 7;
`else
   localparam int NI = 6;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NI-1:0] dout_w;
   logic [NI-1:0] state_w;
   logic [31:0]   count_w [NI];

   pwm #(.period(100), .period_On(50))  u_def   (.clk(clk), .rst(rst), .dout(dout_w[0]));
   pwm #(.period(100), .period_On(0))   u_zero  (.clk(clk), .rst(rst), .dout(dout_w[1]));
   pwm #(.period(100), .period_On(100)) u_full  (.clk(clk), .rst(rst), .dout(dout_w[2]));
   pwm #(.period(100), .period_On(150)) u_clamp (.clk(clk), .rst(rst), .dout(dout_w[3]));
   pwm #(.period(1),   .period_On(1))   u_p1    (.clk(clk), .rst(rst), .dout(dout_w[4]));
   pwm #(.period(3),   .period_On(1))   u_p3    (.clk(clk), .rst(rst), .dout(dout_w[5]));
`ifdef PWM_SIM_INIT_EN
   pwm #(.period(100), .period_On(50))  u_init  (.clk(clk), .rst(1'b0), .dout(dout_w[6]));
   assign count_w[6] = 32'(u_init.count);
   assign state_w[6] = u_init.state;
`endif

   assign count_w[0] = 32'(u_def.count);
   assign count_w[1] = 32'(u_zero.count);
   assign count_w[2] = 32'(u_full.count);
   assign count_w[3] = 32'(u_clamp.count);
   assign count_w[4] = 32'(u_p1.count);
   assign count_w[5] = 32'(u_p3.count);
   assign state_w[0] = u_def.state;
   assign state_w[1] = u_zero.state;
   assign state_w[2] = u_full.state;
   assign state_w[3] = u_clamp.state;
   assign state_w[4] = u_p1.state;
   assign state_w[5] = u_p3.state;

   typedef struct {
      int   idx;
      logic d;
      int   c;
   } exp_t;

   typedef struct {
      logic rst;
      int   n;
      logic exp_dout;
      int   exp_count;
      bit   count_toggles;
   } seg_t;

   exp_t sb[$];
   int   per_a  [NI];
   int   ton_a  [NI];
   int   mc     [NI];
   bit   resettable [NI];
   logic prev_d [NI];
   int   toggles[NI];
   bit   tog_en;
   int   total = 0;
   int   bad   = 0;

   // High/low run tracking on the default instance.
   bit   run_valid;
   int   run_len;
   logic run_prev;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle: the model predicts each instance, the edge happens, then compare.
   task automatic step(input logic r);
      exp_t e;
      rst = r;
      for (int i = 0; i < NI; i++) begin
         e.idx = i;
         if (r && resettable[i]) begin
            e.d   = 1'b0;
            mc[i] = 0;
         end else begin
            e.d   = (mc[i] < ton_a[i]);
            mc[i] = (mc[i] == per_a[i] - 1) ? 0 : mc[i] + 1;
         end
         e.c = mc[i];
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check($sformatf("dout[%0d]", e.idx), 32'(dout_w[e.idx]), 32'(e.d));
         check($sformatf("count[%0d]", e.idx), count_w[e.idx], 32'(e.c));
         check($sformatf("state[%0d]", e.idx), 32'(state_w[e.idx]), 32'(dout_w[e.idx]));
         if (tog_en && dout_w[e.idx] !== prev_d[e.idx]) toggles[e.idx]++;
         prev_d[e.idx] = dout_w[e.idx];
      end
      if (r) begin
         run_valid = 1'b0;
         run_len   = 0;
         run_prev  = 1'b0;
      end else if (dout_w[0] === run_prev) begin
         run_len++;
      end else begin
         if (run_valid) check(run_prev ? "high_run" : "low_run", 32'(run_len), 32'd50);
         run_valid = 1'b1;
         run_len   = 1;
         run_prev  = dout_w[0];
      end
   endtask

   seg_t segs[10];

   initial begin
      per_a[0] = 100; ton_a[0] = 50;
      per_a[1] = 100; ton_a[1] = 0;
      per_a[2] = 100; ton_a[2] = 100;
      per_a[3] = 100; ton_a[3] = 100;
      per_a[4] = 1;   ton_a[4] = 1;
      per_a[5] = 3;   ton_a[5] = 1;
`ifdef PWM_SIM_INIT_EN
      per_a[6] = 100; ton_a[6] = 50;
`endif
      for (int i = 0; i < NI; i++) begin
         mc[i]         = 0;
         toggles[i]    = 0;
         prev_d[i]     = 1'b0;
         resettable[i] = (i < 6);
      end
      tog_en    = 1'b0;
      run_valid = 1'b0;
      run_len   = 0;
      run_prev  = 1'b0;

      // {rst, cycles, default dout after last edge, default count after last edge, toggle window}
      segs[0] = '{1'b1, 2,     1'b0, 0,  1'b0};
      segs[1] = '{1'b0, 10000, 1'b0, 0,  1'b1};
      segs[2] = '{1'b0, 30,    1'b1, 30, 1'b0};
      segs[3] = '{1'b1, 1,     1'b0, 0,  1'b0};
      segs[4] = '{1'b0, 80,    1'b0, 80, 1'b0};
      segs[5] = '{1'b1, 1,     1'b0, 0,  1'b0};
      segs[6] = '{1'b0, 1,     1'b1, 1,  1'b0};
      segs[7] = '{1'b0, 149,   1'b1, 50, 1'b0};
      segs[8] = '{1'b0, 1,     1'b0, 51, 1'b0};
      segs[9] = '{1'b0, 500,   1'b0, 51, 1'b0};

`ifdef PWM_SIM_INIT_EN
      // The free-running instance has never seen reset; the very first edge must raise dout.
      step(1'b1);
      check("init_first_edge", 32'(dout_w[6]), 32'd1);
      step(1'b1);
`else
      step(1'b1);
      step(1'b1);
`endif
      check("reset_dout", 32'(dout_w[0]), 32'd0);
      check("reset_count", count_w[0], 32'd0);
      check("ton_default", 32'(u_def.ton), 32'd50);
      check("ton_zero", 32'(u_zero.ton), 32'd0);
      check("ton_clamped", 32'(u_clamp.ton), 32'd100);
      check("ton_p1", 32'(u_p1.ton), 32'd1);

      for (int s = 1; s < 10; s++) begin
         if (segs[s].count_toggles) begin
            step(segs[s].rst);
            for (int i = 0; i < NI; i++) toggles[i] = 0;
            tog_en = 1'b1;
            for (int k = 1; k < segs[s].n; k++) step(segs[s].rst);
            tog_en = 1'b0;
            check("toggles_default", 32'(toggles[0]), 32'd199);
            check("toggles_zero", 32'(toggles[1]), 32'd0);
            check("toggles_full", 32'(toggles[2]), 32'd0);
            check("toggles_clamp", 32'(toggles[3]), 32'd0);
            check("toggles_p1", 32'(toggles[4]), 32'd0);
            check("level_zero", 32'(dout_w[1]), 32'd0);
            check("level_full", 32'(dout_w[2]), 32'd1);
            check("level_p1", 32'(dout_w[4]), 32'd1);
         end else begin
            for (int k = 0; k < segs[s].n; k++) step(segs[s].rst);
         end
         check($sformatf("seg%0d_dout", s), 32'(dout_w[0]), 32'(segs[s].exp_dout));
         check($sformatf("seg%0d_count", s), count_w[0], 32'(segs[s].exp_count));
      end

      // Period-3 pattern by hand: after a reset, high for one edge then low for two.
      step(1'b1);
      for (int k = 0; k < 6; k++) begin
         step(1'b0);
         check("p3_pattern", 32'(dout_w[5]), (k % 3 == 0) ? 32'd1 : 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pwm.md
# pwm

Fixed-frequency, fixed-duty pulse-width modulator. It drives a single-bit output high for `period_On` clock cycles out of every `period` cycles, repeating forever after reset. It is a free-running leaf block and needs no handshake. Typical loads are LED dimming, motor-drive enables and test-pattern generation.

## Interface
- `period`, default 100: total PWM period in clock cycles; legal range ≥ 1.
- `period_On`, default 50: high-time in clock cycles per period; legal range 0..`period`.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: reset, synchronous and active-high.
- `dout` output 1: PWM waveform; registered.

## Operation
- Internal registers use these exact names, because benches probe them hierarchically:
  - `count`: position in the period, unsigned, `$clog2(period)` bits, minimum 1 bit.
  - `ton`: active high-time, unsigned, one bit wider than `count`.
  - `state`: 1-bit phase; S_ON = 1'b1, S_OFF = 1'b0.
- Reset edge (`rst`=1 at a rising `clk`):
  - `count`←0, `ton`←effective high-time, `state`←S_OFF, `dout`←0.
  - Reset dominates every other update.
- Effective high-time:
  - equals `period_On`;
  - if `period_On` > `period`, it is clamped to `period`;
  - it is an elaboration-time constant and is loaded into `ton` at reset.
- Every non-reset edge:
  - `dout` ← (`count` < `ton`), evaluated on the pre-edge `count`.
  - `state` ← S_ON when the new `dout` = 1, otherwise S_OFF.
  - `count` ← 0 if `count` = `period`−1, otherwise `count`+1.
- Invariant: `dout` == `state` at all times after the first clock edge.
- Boundary values:
  - `period_On` = 0: `dout` stays 0 permanently.
  - `period_On` = `period`: `dout` stays 1 from the first edge after reset.
  - `period` = 1: `count` stays 0.
- Reset mid-operation: the waveform aborts on that edge, `dout` = 0, and a fresh period starts on the first edge with `rst` = 0.
- `ton` is written only at reset.

## Timing
- Latency: the first `dout` = 1 appears on the first rising edge with `rst` = 0 after a reset edge, provided `period_On` > 0.
- Each period is exactly `period` cycles: `period_On` cycles high, then `period` − `period_On` cycles low.
- The rising edge of `dout` coincides with the edge on which `count` goes 0→1.
- The falling edge of `dout` occurs on the edge where pre-edge `count` = `ton`.
- The output is glitch-free: a single flop drives `dout`, with no combinational path to the port.

## Configuration
- Macro `PWM_SIM_INIT_EN`.
  - Defined: `count`, `ton`, `state` and `dout` carry declaration-time initial values equal to their reset values. Simulations and FPGA builds that never assert `rst` then produce a valid waveform from time 0; the first edge drives `dout` = 1.
  - Undefined: no initial values are declared, registers are X until the first reset edge, and ASIC-safe RTL is produced.
  - Reset behaviour is identical either way.

## Structure
- Shared package `pwm_pkg` holds:
  - the state typedef `pwm_state_t` (S_OFF = 1'b0, S_ON = 1'b1);
  - a width helper function returning max(1, `$clog2(n)`).
- No sub-module: the counter, compare and output flop stay inline in `pwm`.
- Parameter legality is checked by an elaboration-time assertion that `period` ≥ 1. `period_On` > `period` is clamped, not rejected.

## Test plan
- Defaults (100/50): reset 2 cycles, release, run 10000 cycles.
  - Expected: `dout` high exactly 50 cycles, low exactly 50, period 100.
  - Expected: `count` wraps 99→0.
  - Expected: `state` == `dout` throughout.
- `period_On` = 0 and `period_On` = 100 (period 100), run 500 cycles.
  - Expected: `dout` constant 0 in the first case and constant 1 in the second.
  - Expected: no toggles in either case.
- `period_On` = 150, `period` = 100.
  - Expected: `ton` = 100 after reset.
  - Expected: `dout` constant 1.
- Reset asserted mid-high (cycle 30) and mid-low (cycle 80) for 1 cycle.
  - Expected: next edge `dout` = 0 and `count` = 0.
  - Expected: a fresh 50-high/50-low period starts after release.
- `period` = 1 with `period_On` = 1, and `period` = 3 with `period_On` = 1.
  - Expected: constant 1 in the first case.
  - Expected: 1-high/2-low repeating in the second.
- Build with `PWM_SIM_INIT_EN` and never assert `rst`.
  - Expected: `dout` = 1 at the first edge.
  - Expected: a correct 50/50 waveform from time 0, with no X on `dout`.
